// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC controller.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, BIT, DONE} state_t;

  localparam int OVS_CNT = 4;

  function automatic int cnt_width(input int sample_cyc, input int settle_cyc);
    int m;
    m = (sample_cyc > settle_cyc) ? sample_cyc : settle_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output is two clocks behind the input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample, N bit trials, one-cycle done with held result.
// Optional SAR_OVERSAMPLE4_EN: four back-to-back conversions averaged into one result.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int N          = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         cmp_in,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = cnt_width(SAMPLE_CYC, SETTLE_CYC);
  localparam int IW = idx_width(N);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] BIT_MSB     = IW'(N - 1);
  localparam logic [N-1:0]  ONE         = N'(1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   w_q, w_d;
  logic [N-1:0]   result_q, result_d;
  logic           cmp_s;

`ifdef SAR_OVERSAMPLE4_EN
  localparam logic [1:0] OVS_LAST = 2'(OVS_CNT - 1);
  logic [N+1:0]   acc_q, acc_d;
  logic [1:0]     ovs_q, ovs_d;
`endif

  sync_2ff u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    w_d      = w_q;
    result_d = result_q;
`ifdef SAR_OVERSAMPLE4_EN
    acc_d    = acc_q;
    ovs_d    = ovs_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = '0;
`ifdef SAR_OVERSAMPLE4_EN
          acc_d   = '0;
          ovs_d   = '0;
`endif
        end
      end
      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = BIT;
          cnt_d   = '0;
          idx_d   = BIT_MSB;
          w_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d      = '0;
          w_d[idx_q] = cmp_s;
          if (idx_q == '0) begin
`ifdef SAR_OVERSAMPLE4_EN
            acc_d = acc_q + {2'b00, w_d};
            if (ovs_q == OVS_LAST) begin
              state_d  = DONE;
              result_d = acc_d[N+1:2];
            end else begin
              state_d = SAMPLE;
              ovs_d   = ovs_q + 2'd1;
            end
`else
            state_d  = DONE;
            result_d = w_d;
`endif
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abort never publishes a result, even on the final bit decision.
    if (!ena) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      w_q      <= '0;
      result_q <= '0;
`ifdef SAR_OVERSAMPLE4_EN
      acc_q    <= '0;
      ovs_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      result_q <= result_d;
`ifdef SAR_OVERSAMPLE4_EN
      acc_q    <= acc_d;
      ovs_q    <= ovs_d;
`endif
    end
  end

  assign sample   = (state_q == SAMPLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign dac_code = (state_q == BIT) ? (w_q | (ONE << idx_q)) : '0;
  assign result   = result_q;

endmodule
